// File: rtl/lc3b_pipe_ctrl.sv
// Hazard, stall and forwarding controller for the 5-stage LC-3b pipeline.
// Optional performance counters are enabled by defining PIPE_PERF_CNT_EN.
module lc3b_pipe_ctrl #(
    parameter int unsigned MEM_TIMEOUT = 255,
    parameter int unsigned CNT_W       = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] i_id_src1,
    input  logic [2:0] i_id_src2,
    input  logic       i_id_use1,
    input  logic       i_id_use2,
    input  logic [2:0] i_ex_src1,
    input  logic [2:0] i_ex_src2,
    input  logic       i_ex_ir5,
    input  logic [2:0] i_ex_dest,
    input  logic       i_ex_regwrite,
    input  logic       i_ex_memread,
    input  logic [2:0] i_mem_dest,
    input  logic [2:0] i_wb_dest,
    input  logic       i_mem_regwrite,
    input  logic       i_wb_regwrite,
    input  logic       i_imem_req,
    input  logic       i_imem_resp,
    input  logic       i_dmem_req,
    input  logic       i_dmem_resp,
    input  logic       i_br_taken,
    output logic       o_pc_load,
    output logic       o_if_id_load,
    output logic       o_id_ex_load,
    output logic       o_ex_mem_load,
    output logic       o_mem_wb_load,
    output logic       o_if_id_flush,
    output logic       o_id_ex_flush,
    output logic       o_ex_mem_flush,
    output logic [1:0] o_fwd_a,
    output logic [1:0] o_fwd_b,
`ifdef PIPE_PERF_CNT_EN
    output logic [15:0] o_stall_cycles,
    output logic [15:0] o_bubble_cycles,
    output logic [15:0] o_flush_events,
`endif
    output logic       o_mem_err
);

    typedef enum logic [1:0] {StRun, StMemWait, StError} state_t;

    localparam logic [CNT_W-1:0] TimeoutCnt = CNT_W'(MEM_TIMEOUT);

    state_t           r_state;
    logic [CNT_W-1:0] r_wait_cnt;

    logic w_miss;
    logic w_load_use;
    logic w_freeze;
    logic w_redirect;
    logic w_bubble;

    assign w_miss = (i_imem_req & ~i_imem_resp) | (i_dmem_req & ~i_dmem_resp);

    assign w_load_use = i_ex_memread & i_ex_regwrite &
                        ((i_id_use1 & (i_id_src1 == i_ex_dest)) |
                         (i_id_use2 & (i_id_src2 == i_ex_dest)));

    assign w_freeze   = ~reset & ((r_state == StError) | w_miss);
    assign w_redirect = ~reset & ~w_freeze & i_br_taken;
    assign w_bubble   = ~reset & ~w_freeze & ~i_br_taken & w_load_use;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= StRun;
            r_wait_cnt <= '0;
        end else begin
            unique case (r_state)
                StRun: begin
                    if (w_miss) begin
                        r_state    <= StMemWait;
                        r_wait_cnt <= CNT_W'(1);
                    end
                end
                StMemWait: begin
                    if (!w_miss) begin
                        r_state    <= StRun;
                        r_wait_cnt <= '0;
                    end else if ((MEM_TIMEOUT != 0) && (r_wait_cnt == TimeoutCnt)) begin
                        r_state <= StError;
                    end else if (r_wait_cnt != '1) begin
                        r_wait_cnt <= r_wait_cnt + CNT_W'(1);
                    end
                end
                StError: r_state <= StError;
                default: begin
                    r_state    <= StRun;
                    r_wait_cnt <= '0;
                end
            endcase
        end
    end

    // Flush dominates load in the pipeline registers, so loads stay 1 on redirect/bubble.
    always_comb begin
        o_pc_load      = 1'b1;
        o_if_id_load   = 1'b1;
        o_id_ex_load   = 1'b1;
        o_ex_mem_load  = 1'b1;
        o_mem_wb_load  = 1'b1;
        o_if_id_flush  = 1'b0;
        o_id_ex_flush  = 1'b0;
        o_ex_mem_flush = 1'b0;
        if (reset) begin
            o_pc_load      = 1'b0;
            o_if_id_load   = 1'b0;
            o_id_ex_load   = 1'b0;
            o_ex_mem_load  = 1'b0;
            o_mem_wb_load  = 1'b0;
            o_if_id_flush  = 1'b1;
            o_id_ex_flush  = 1'b1;
            o_ex_mem_flush = 1'b1;
        end else if (w_freeze) begin
            o_pc_load     = 1'b0;
            o_if_id_load  = 1'b0;
            o_id_ex_load  = 1'b0;
            o_ex_mem_load = 1'b0;
            o_mem_wb_load = 1'b0;
        end else if (w_redirect) begin
            o_if_id_flush  = 1'b1;
            o_id_ex_flush  = 1'b1;
            o_ex_mem_flush = 1'b1;
        end else if (w_bubble) begin
            o_pc_load     = 1'b0;
            o_if_id_load  = 1'b0;
            o_id_ex_flush = 1'b1;
        end
    end

    always_comb begin
        o_fwd_a = 2'b00;
        o_fwd_b = 2'b00;
        if (!reset) begin
            if (i_mem_regwrite && (i_mem_dest == i_ex_src1)) begin
                o_fwd_a = 2'b01;
            end else if (i_wb_regwrite && (i_wb_dest == i_ex_src1)) begin
                o_fwd_a = 2'b10;
            end
            if (!i_ex_ir5) begin
                if (i_mem_regwrite && (i_mem_dest == i_ex_src2)) begin
                    o_fwd_b = 2'b01;
                end else if (i_wb_regwrite && (i_wb_dest == i_ex_src2)) begin
                    o_fwd_b = 2'b10;
                end
            end
        end
    end

    assign o_mem_err = (r_state == StError);

`ifdef PIPE_PERF_CNT_EN
    logic [15:0] r_stall_cycles;
    logic [15:0] r_bubble_cycles;
    logic [15:0] r_flush_events;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_stall_cycles  <= '0;
            r_bubble_cycles <= '0;
            r_flush_events  <= '0;
        end else begin
            if (w_freeze && (r_stall_cycles != 16'hFFFF)) begin
                r_stall_cycles <= r_stall_cycles + 16'd1;
            end
            if (w_bubble && (r_bubble_cycles != 16'hFFFF)) begin
                r_bubble_cycles <= r_bubble_cycles + 16'd1;
            end
            if (w_redirect && (r_flush_events != 16'hFFFF)) begin
                r_flush_events <= r_flush_events + 16'd1;
            end
        end
    end

    assign o_stall_cycles  = r_stall_cycles;
    assign o_bubble_cycles = r_bubble_cycles;
    assign o_flush_events  = r_flush_events;
`endif

endmodule

// File: tb/tb_lc3b_pipe_ctrl.sv
// Directed self-checking bench for lc3b_pipe_ctrl: instance A uses the default
// watchdog limit, instance B uses MEM_TIMEOUT=4.
module tb_lc3b_pipe_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [2:0] id_src1, id_src2, ex_src1, ex_src2, ex_dest, mem_dest, wb_dest;
    logic       id_use1, id_use2, ex_ir5, ex_regwrite, ex_memread;
    logic       mem_regwrite, wb_regwrite;
    logic       imem_req, imem_resp, dmem_req, dmem_resp, br_taken;

    logic       pc_a, ifid_a, idex_a, exmem_a, memwb_a, ifidf_a, idexf_a, exmemf_a, err_a;
    logic       pc_b, ifid_b, idex_b, exmem_b, memwb_b, ifidf_b, idexf_b, exmemf_b, err_b;
    logic [1:0] fa_a, fb_a, fa_b, fb_b;

    int n_asserts = 0;
    int n_fail    = 0;

    // Observation word: {loads[4:0], flushes[2:0], fwd_a, fwd_b, mem_err}
    logic [12:0] obs_a, obs_b;
    assign obs_a = {pc_a, ifid_a, idex_a, exmem_a, memwb_a, ifidf_a, idexf_a, exmemf_a,
                    fa_a, fb_a, err_a};
    assign obs_b = {pc_b, ifid_b, idex_b, exmem_b, memwb_b, ifidf_b, idexf_b, exmemf_b,
                    fa_b, fb_b, err_b};

    localparam logic [12:0] ExpRst    = 13'b00000_111_00_00_0;
    localparam logic [12:0] ExpNormal = 13'b11111_000_00_00_0;
    localparam logic [12:0] ExpFreeze = 13'b00000_000_00_00_0;
    localparam logic [12:0] ExpRedir  = 13'b11111_111_00_00_0;
    localparam logic [12:0] ExpBubble = 13'b00111_010_00_00_0;
    localparam logic [12:0] ExpErr    = 13'b00000_000_00_00_1;

    always #5 clk = ~clk;

    lc3b_pipe_ctrl u_dut_a (
        .clk(clk), .reset(reset),
        .i_id_src1(id_src1), .i_id_src2(id_src2), .i_id_use1(id_use1), .i_id_use2(id_use2),
        .i_ex_src1(ex_src1), .i_ex_src2(ex_src2), .i_ex_ir5(ex_ir5), .i_ex_dest(ex_dest),
        .i_ex_regwrite(ex_regwrite), .i_ex_memread(ex_memread),
        .i_mem_dest(mem_dest), .i_wb_dest(wb_dest),
        .i_mem_regwrite(mem_regwrite), .i_wb_regwrite(wb_regwrite),
        .i_imem_req(imem_req), .i_imem_resp(imem_resp),
        .i_dmem_req(dmem_req), .i_dmem_resp(dmem_resp), .i_br_taken(br_taken),
        .o_pc_load(pc_a), .o_if_id_load(ifid_a), .o_id_ex_load(idex_a),
        .o_ex_mem_load(exmem_a), .o_mem_wb_load(memwb_a),
        .o_if_id_flush(ifidf_a), .o_id_ex_flush(idexf_a), .o_ex_mem_flush(exmemf_a),
        .o_fwd_a(fa_a), .o_fwd_b(fb_a), .o_mem_err(err_a)
    );

    lc3b_pipe_ctrl #(.MEM_TIMEOUT(4), .CNT_W(8)) u_dut_b (
        .clk(clk), .reset(reset),
        .i_id_src1(id_src1), .i_id_src2(id_src2), .i_id_use1(id_use1), .i_id_use2(id_use2),
        .i_ex_src1(ex_src1), .i_ex_src2(ex_src2), .i_ex_ir5(ex_ir5), .i_ex_dest(ex_dest),
        .i_ex_regwrite(ex_regwrite), .i_ex_memread(ex_memread),
        .i_mem_dest(mem_dest), .i_wb_dest(wb_dest),
        .i_mem_regwrite(mem_regwrite), .i_wb_regwrite(wb_regwrite),
        .i_imem_req(imem_req), .i_imem_resp(imem_resp),
        .i_dmem_req(dmem_req), .i_dmem_resp(dmem_resp), .i_br_taken(br_taken),
        .o_pc_load(pc_b), .o_if_id_load(ifid_b), .o_id_ex_load(idex_b),
        .o_ex_mem_load(exmem_b), .o_mem_wb_load(memwb_b),
        .o_if_id_flush(ifidf_b), .o_id_ex_flush(idexf_b), .o_ex_mem_flush(exmemf_b),
        .o_fwd_a(fa_b), .o_fwd_b(fb_b), .o_mem_err(err_b)
    );

    task automatic clear_inputs;
        id_src1 = 3'd0; id_src2 = 3'd0; id_use1 = 1'b0; id_use2 = 1'b0;
        ex_src1 = 3'd0; ex_src2 = 3'd0; ex_ir5 = 1'b0; ex_dest = 3'd0;
        ex_regwrite = 1'b0; ex_memread = 1'b0;
        mem_dest = 3'd0; wb_dest = 3'd0; mem_regwrite = 1'b0; wb_regwrite = 1'b0;
        imem_req = 1'b0; imem_resp = 1'b0; dmem_req = 1'b0; dmem_resp = 1'b0;
        br_taken = 1'b0;
    endtask

    task automatic next_cycle;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        clear_inputs();
        reset = 1'b1;
        next_cycle();
        next_cycle();
        reset = 1'b0;
    endtask

    task automatic test_reset;
        clear_inputs();
        reset = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            n_asserts++;
            if (obs_a !== ExpRst) begin
                n_fail++;
                $display("FAIL reset_hold_a cyc%0d: got %b want %b", i, obs_a, ExpRst);
            end
            n_asserts++;
            if (obs_b !== ExpRst) begin
                n_fail++;
                $display("FAIL reset_hold_b cyc%0d: got %b want %b", i, obs_b, ExpRst);
            end
            next_cycle();
        end
        reset = 1'b0;
        @(negedge clk);
        n_asserts++;
        if (obs_a !== ExpNormal) begin
            n_fail++;
            $display("FAIL reset_release_a: got %b want %b", obs_a, ExpNormal);
        end
        n_asserts++;
        if (obs_b !== ExpNormal) begin
            n_fail++;
            $display("FAIL reset_release_b: got %b want %b", obs_b, ExpNormal);
        end
        next_cycle();
    endtask

    task automatic test_load_use;
        clear_inputs();
        ex_memread = 1'b1; ex_regwrite = 1'b1; ex_dest = 3'd3; id_src1 = 3'd3; id_use1 = 1'b1;
        @(negedge clk);
        n_asserts++;
        if (obs_a !== ExpBubble) begin
            n_fail++;
            $display("FAIL load_use_src1: got %b want %b", obs_a, ExpBubble);
        end
        next_cycle();
        // Load moved to MEM, bubble now in EX.
        ex_memread = 1'b0; ex_regwrite = 1'b0; mem_dest = 3'd3; mem_regwrite = 1'b1;
        @(negedge clk);
        n_asserts++;
        if (obs_a !== ExpNormal) begin
            n_fail++;
            $display("FAIL load_use_after: got %b want %b", obs_a, ExpNormal);
        end
        next_cycle();
        clear_inputs();
        ex_memread = 1'b1; ex_regwrite = 1'b1; ex_dest = 3'd6; id_src1 = 3'd6; id_use1 = 1'b0;
        @(negedge clk);
        n_asserts++;
        if (obs_a !== ExpNormal) begin
            n_fail++;
            $display("FAIL load_use_unused_src: got %b want %b", obs_a, ExpNormal);
        end
        next_cycle();
        id_src2 = 3'd6; id_use2 = 1'b1;
        @(negedge clk);
        n_asserts++;
        if (obs_a !== ExpBubble) begin
            n_fail++;
            $display("FAIL load_use_src2: got %b want %b", obs_a, ExpBubble);
        end
        next_cycle();
        ex_regwrite = 1'b0;
        @(negedge clk);
        n_asserts++;
        if (obs_a !== ExpNormal) begin
            n_fail++;
            $display("FAIL load_use_no_regwrite: got %b want %b", obs_a, ExpNormal);
        end
        next_cycle();
        ex_regwrite = 1'b1; br_taken = 1'b1;
        @(negedge clk);
        n_asserts++;
        if (obs_a !== ExpRedir) begin
            n_fail++;
            $display("FAIL load_use_vs_branch: got %b want %b", obs_a, ExpRedir);
        end
        next_cycle();
        clear_inputs();
    endtask

    task automatic test_forwarding;
        logic [3:0] exp_fwd [5];
        exp_fwd[0] = 4'b01_00;
        exp_fwd[1] = 4'b01_01;
        exp_fwd[2] = 4'b10_10;
        exp_fwd[3] = 4'b00_00;
        exp_fwd[4] = 4'b01_10;
        for (int i = 0; i < 5; i++) begin
            clear_inputs();
            mem_regwrite = 1'b1; mem_dest = 3'd2; wb_regwrite = 1'b1; wb_dest = 3'd2;
            ex_src1 = 3'd2; ex_src2 = 3'd2; ex_ir5 = 1'b1;
            case (i)
                1: ex_ir5 = 1'b0;
                2: begin ex_ir5 = 1'b0; mem_dest = 3'd5; end
                3: begin ex_ir5 = 1'b0; mem_dest = 3'd5; wb_regwrite = 1'b0; end
                4: begin ex_ir5 = 1'b0; mem_dest = 3'd5; ex_src1 = 3'd5; end
                default: ;
            endcase
            @(negedge clk);
            n_asserts++;
            if ({fa_a, fb_a} !== exp_fwd[i]) begin
                n_fail++;
                $display("FAIL fwd_case%0d: got %b want %b", i, {fa_a, fb_a}, exp_fwd[i]);
            end
            next_cycle();
        end
        clear_inputs();
    endtask

    task automatic test_miss_redirect;
        clear_inputs();
        dmem_req = 1'b1; dmem_resp = 1'b0; br_taken = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_asserts++;
            if (obs_a !== ExpFreeze) begin
                n_fail++;
                $display("FAIL miss_freeze cyc%0d: got %b want %b", i, obs_a, ExpFreeze);
            end
            next_cycle();
        end
        dmem_resp = 1'b1;
        @(negedge clk);
        n_asserts++;
        if (obs_a !== ExpRedir) begin
            n_fail++;
            $display("FAIL miss_release_redirect: got %b want %b", obs_a, ExpRedir);
        end
        next_cycle();
        clear_inputs();
        @(negedge clk);
        n_asserts++;
        if (obs_a !== ExpNormal) begin
            n_fail++;
            $display("FAIL miss_after_redirect: got %b want %b", obs_a, ExpNormal);
        end
        next_cycle();
        do_reset();
    endtask

    task automatic test_watchdog;
        clear_inputs();
        imem_req = 1'b1; imem_resp = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_asserts++;
            if (obs_b !== ExpFreeze) begin
                n_fail++;
                $display("FAIL wdog_wait cyc%0d: got %b want %b", i, obs_b, ExpFreeze);
            end
            next_cycle();
        end
        @(negedge clk);
        n_asserts++;
        if (obs_b !== ExpErr) begin
            n_fail++;
            $display("FAIL wdog_error: got %b want %b", obs_b, ExpErr);
        end
        n_asserts++;
        if (obs_a !== ExpFreeze) begin
            n_fail++;
            $display("FAIL wdog_default_limit: got %b want %b", obs_a, ExpFreeze);
        end
        next_cycle();
        imem_resp = 1'b1;
        mem_regwrite = 1'b1; mem_dest = 3'd1; ex_src1 = 3'd1;
        @(negedge clk);
        n_asserts++;
        if (obs_b !== 13'b00000_000_01_00_1) begin
            n_fail++;
            $display("FAIL wdog_sticky: got %b want %b", obs_b, 13'b00000_000_01_00_1);
        end
        n_asserts++;
        if (obs_a !== 13'b11111_000_01_00_0) begin
            n_fail++;
            $display("FAIL wdog_a_released: got %b want %b", obs_a, 13'b11111_000_01_00_0);
        end
        next_cycle();
        clear_inputs();
        reset = 1'b1;
        next_cycle();
        @(negedge clk);
        n_asserts++;
        if (obs_b !== ExpRst) begin
            n_fail++;
            $display("FAIL wdog_in_reset: got %b want %b", obs_b, ExpRst);
        end
        next_cycle();
        reset = 1'b0;
        @(negedge clk);
        n_asserts++;
        if (obs_b !== ExpNormal) begin
            n_fail++;
            $display("FAIL wdog_cleared: got %b want %b", obs_b, ExpNormal);
        end
        next_cycle();
    endtask

    task automatic test_reset_mid_wait;
        clear_inputs();
        imem_req = 1'b1;
        for (int i = 0; i < 3; i++) next_cycle();
        reset = 1'b1;
        @(negedge clk);
        n_asserts++;
        if (obs_b !== ExpRst) begin
            n_fail++;
            $display("FAIL midwait_reset: got %b want %b", obs_b, ExpRst);
        end
        next_cycle();
        reset = 1'b0;
        imem_req = 1'b0;
        @(negedge clk);
        n_asserts++;
        if (obs_b !== ExpNormal) begin
            n_fail++;
            $display("FAIL midwait_after_reset: got %b want %b", obs_b, ExpNormal);
        end
        next_cycle();
        // A 2-cycle miss, then a 4-cycle miss (at the limit): neither may trip the watchdog.
        for (int len = 2; len <= 4; len += 2) begin
            imem_req = 1'b1;
            for (int i = 0; i < len; i++) begin
                @(negedge clk);
                n_asserts++;
                if (obs_b !== ExpFreeze) begin
                    n_fail++;
                    $display("FAIL midwait_miss%0d cyc%0d: got %b want %b",
                             len, i, obs_b, ExpFreeze);
                end
                next_cycle();
            end
            imem_resp = 1'b1;
            @(negedge clk);
            n_asserts++;
            if (obs_b !== ExpNormal) begin
                n_fail++;
                $display("FAIL midwait_release%0d: got %b want %b", len, obs_b, ExpNormal);
            end
            next_cycle();
            clear_inputs();
        end
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_forwarding();
        test_miss_redirect();
        test_watchdog();
        test_reset_mid_wait();
        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule

// File: doc/lc3b_pipe_ctrl.md
Name: lc3b_pipe_ctrl

Overview:
Central hazard and stall controller for the 5-stage LC-3b pipeline. It drives the load and flush (synchronous reset) inputs of the IF/ID, ID/EX, EX/MEM and MEM/WB registers and the PC. It consumes the ID/EX register's src1/src2/ir5 outputs to generate EX-stage forwarding selects. It also tracks multi-cycle memory waits with a timeout watchdog.

Parameters:
MEM_TIMEOUT, 255, max consecutive wait cycles before fatal error; 0 disables watchdog
CNT_W, 8, width of wait counter; must hold MEM_TIMEOUT

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high
id_src1, id_src2  in  3  source regs of instruction in ID
id_use1, id_use2  in  1  ID instruction actually reads src1/src2
ex_src1, ex_src2  in  3  ID/EX src1_out/src2_out
ex_ir5  in  1  ID/EX ir5_out; 1 = immediate, src2 unused
ex_dest  in  3  EX-stage destination
ex_regwrite, ex_memread  in  1  EX instruction writes reg / is a load
mem_dest, wb_dest  in  3  MEM/WB-stage destinations
mem_regwrite, wb_regwrite  in  1  write enables in MEM/WB
imem_req, imem_resp  in  1  fetch request / data ready this cycle
dmem_req, dmem_resp  in  1  data-memory request / ready this cycle
br_taken  in  1  redirect resolved in MEM (level, from EX/MEM register)
pc_load, if_id_load, id_ex_load, ex_mem_load, mem_wb_load  out  1  register loads
if_id_flush, id_ex_flush, ex_mem_flush  out  1  drive register reset inputs
fwd_a, fwd_b  out  2  00 = regfile, 01 = MEM result, 10 = WB result
mem_err  out  1  sticky watchdog error

Behaviour:
- FSM states: RUN, MEM_WAIT, ERROR. Registered state; wait_cnt (CNT_W bits); outputs combinational from state plus inputs.
- Reset: state=RUN, wait_cnt=0, mem_err=0. While reset=1: all loads 0, all flushes 1, fwd_a=fwd_b=00.
- miss = (imem_req & ~imem_resp) | (dmem_req & ~dmem_resp).
- Priority each cycle: ERROR > miss > br_taken > load-use > normal.
- Freeze (miss in RUN or MEM_WAIT): all loads 0, all flushes 0; pipeline holds. br_taken stays asserted because EX/MEM is frozen; it is serviced in the first non-miss cycle.
- Redirect (br_taken, no miss): pc_load=1; if_id_flush=id_ex_flush=ex_mem_flush=1; mem_wb_load=1 so the branch retires. Load-use is ignored that cycle.
- Load-use: ex_memread & ex_regwrite & ((id_use1 & id_src1==ex_dest) | (id_use2 & id_src2==ex_dest)). Response: pc_load=0, if_id_load=0, id_ex_flush=1 (bubble); ex_mem_load=mem_wb_load=1. Exactly one bubble, because the load advances to MEM next cycle.
- Normal: all loads 1, flushes 0.
- Forwarding:
  - fwd_a=01 if mem_regwrite & mem_dest==ex_src1; else 10 if wb_regwrite & wb_dest==ex_src1; else 00. MEM wins on a double match.
  - fwd_b uses the same rule on ex_src2, forced 00 when ex_ir5=1.
  - Forwarding is combinational and independent of state.
- Transitions:
  - RUN→MEM_WAIT on miss; wait_cnt←1.
  - MEM_WAIT: if ~miss → RUN, wait_cnt←0; this is the release cycle, and it applies normal, redirect or load-use rules.
  - MEM_WAIT: else if MEM_TIMEOUT≠0 and wait_cnt==MEM_TIMEOUT → ERROR; else wait_cnt++.
  - ERROR: mem_err=1, full freeze, no exit except reset.
- Reset asserted mid-wait returns to RUN with wait_cnt=0 on the next edge.
- wait_cnt never wraps.

Optional Feature:
PIPE_PERF_CNT_EN
- Defined: adds outputs stall_cycles, bubble_cycles, flush_events (16 bits each, saturating at 16'hFFFF, cleared by reset). Each increments on a freeze cycle, a load-use bubble cycle, and a redirect cycle respectively.
- Undefined: the ports and counters do not exist; all other behaviour is identical.

Test Plan:
1. Reset held 2 cycles then released, no requests → during reset loads=0, flushes=1; after release all loads=1, flushes=0, fwd_a=fwd_b=00, mem_err=0.
2. ex_memread=1, ex_regwrite=1, ex_dest=3, id_src1=3, id_use1=1 → one cycle with pc_load=0, if_id_load=0, id_ex_flush=1; next cycle normal.
3. mem_regwrite=1, mem_dest=2, wb_regwrite=1, wb_dest=2, ex_src1=2, ex_src2=2, ex_ir5=1 → fwd_a=01, fwd_b=00; with ex_ir5=0 → fwd_b=01.
4. dmem_req=1, dmem_resp=0 for 5 cycles, br_taken=1 throughout, then dmem_resp=1 → 5 frozen cycles (all loads 0), then one redirect cycle: pc_load=1, three flushes=1, mem_wb_load=1.
5. MEM_TIMEOUT=4, imem_req=1, imem_resp=0 held → after 5 cycles state=ERROR, mem_err=1, frozen; imem_resp=1 does not clear it; reset clears mem_err.
6. Reset asserted on the 3rd MEM_WAIT cycle → next cycle RUN, wait_cnt=0, a subsequent 2-cycle miss releases normally with no error.
